// File: rtl/slowfast_pkg.sv
// slowfast_pkg: shared constants and helpers for the fast-to-slow crossing path
package slowfast_pkg;
  localparam int DEFAULT_DATA_W = 4;
  localparam int SYNC_LAT = 2;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fast_word_pacer_if.sv
// fast_word_pacer_if: producer handshake and paced output bus of the word pacer
interface fast_word_pacer_if import slowfast_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH = 4,
  parameter int UCNT_W = 8
);
  logic in_valid;
  logic [DATA_W-1:0] in_data;
  logic in_ready;
  logic [DATA_W-1:0] out_data;
  logic out_load;
  logic out_valid;
  logic [lvl_w(DEPTH)-1:0] fifo_level;
  logic [UCNT_W-1:0] underrun_cnt;
  modport master (output in_valid, in_data, input in_ready, out_data, out_load, out_valid, fifo_level, underrun_cnt);
  modport slave (input in_valid, in_data, output in_ready, out_data, out_load, out_valid, fifo_level, underrun_cnt);
endinterface

// File: rtl/bclk_edge_sync.sv
// bclk_edge_sync: 3-flop Bclk synchronizer with a one-cycle rising-edge slot
module bclk_edge_sync (
  input  logic Aclk,
  input  logic reset,
  input  logic bclk_i,
  output logic slot_o
);
  logic [2:0] s_q;
  always_ff @(posedge Aclk) s_q <= reset ? 3'b000 : {s_q[1:0], bclk_i};
  assign slot_o = s_q[1] & ~s_q[2];
endmodule

// File: rtl/fast_word_pacer.sv
// fast_word_pacer: buffers Aclk words and releases at most one per Bclk period on a held bus
module fast_word_pacer import slowfast_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH = 4,
  parameter int UCNT_W = 8
) (
  input logic Aclk,
  input logic reset,
  input logic Bclk,
  fast_word_pacer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  logic slot, push, pop;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic load_q, load_d, valid_q, valid_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  bclk_edge_sync u_sync (.Aclk(Aclk), .reset(reset), .bclk_i(Bclk), .slot_o(slot));
  assign bus.in_ready = (lvl_q < FULL) & ~reset;
  assign push = bus.in_valid & bus.in_ready;
  assign pop = slot & (lvl_q != '0);
  // an empty slot only counts once something has been presented downstream
  always_comb begin
    wp_d = push ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    lvl_d = lvl_q + LW'(push) - LW'(pop);
    data_d = pop ? mem_q[rp_q] : data_q;
    load_d = pop;
    valid_d = valid_q | pop;
    ucnt_d = (slot & ~pop & valid_q & ~&ucnt_q) ? ucnt_q + UCNT_W'(1) : ucnt_q;
  end
  always_ff @(posedge Aclk) if (push) mem_q[wp_q] <= bus.in_data;
  always_ff @(posedge Aclk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
      data_q <= '0;
      load_q <= 1'b0;
      valid_q <= 1'b0;
      ucnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      lvl_q <= lvl_d;
      data_q <= data_d;
      load_q <= load_d;
      valid_q <= valid_d;
      ucnt_q <= ucnt_d;
    end
  end
  assign bus.out_data = data_q;
  assign bus.out_load = load_q;
  assign bus.out_valid = valid_q;
  assign bus.fifo_level = lvl_q;
  assign bus.underrun_cnt = ucnt_q;
endmodule
